// File: rtl/pipeline_id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, external hold
// and a saturating count of load-use bubbles.
`default_nettype none

module pipeline_id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic              clk_IDEX,
  input  logic              rst_IDEX,
  input  logic              en_IDEX,
  input  logic              flush_IDEX,
  input  logic              valid_in,
  input  logic [XLEN-1:0]   PC_in,
  input  logic [XLEN-1:0]   Rs1_data_in,
  input  logic [XLEN-1:0]   Rs2_data_in,
  input  logic [4:0]        Rs1_addr_in,
  input  logic [4:0]        Rs2_addr_in,
  input  logic [4:0]        Rd_addr_in,
  input  logic              Rs1_used_in,
  input  logic              Rs2_used_in,
  input  logic [XLEN-1:0]   Imm_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid_out,
  output logic [XLEN-1:0]   PC_out,
  output logic [XLEN-1:0]   Rs1_data_out,
  output logic [XLEN-1:0]   Rs2_data_out,
  output logic [4:0]        Rs1_addr_out,
  output logic [4:0]        Rs2_addr_out,
  output logic [4:0]        Rd_addr_out,
  output logic [XLEN-1:0]   Imm_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_ld_ex;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hz;
  logic w_bubble;

  // A load is in EX when it writes a register from memory (MemtoReg = 01) and Rd is not x0.
  assign w_ld_ex   = valid_out & ctrl_out[15] & (ctrl_out[14:13] == 2'b01) & (Rd_addr_out != 5'd0);
  assign w_rs1_hit = Rs1_used_in & (Rs1_addr_in == Rd_addr_out);
  assign w_rs2_hit = Rs2_used_in & (Rs2_addr_in == Rd_addr_out);
  assign w_hz      = w_ld_ex & valid_in & (w_rs1_hit | w_rs2_hit);
  assign stall_out = w_hz & ~flush_IDEX;

  // Flush bubbles even while held; a hazard bubble only happens on an advancing edge.
  assign w_bubble  = flush_IDEX | (en_IDEX & w_hz);

  always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      valid_out    <= 1'b0;
      PC_out       <= '0;
      Rs1_data_out <= '0;
      Rs2_data_out <= '0;
      Rs1_addr_out <= '0;
      Rs2_addr_out <= '0;
      Rd_addr_out  <= '0;
      Imm_out      <= '0;
      ctrl_out     <= '0;
      bubble_cnt   <= '0;
    end else if (w_bubble) begin
      valid_out    <= 1'b0;
      PC_out       <= '0;
      Rs1_data_out <= '0;
      Rs2_data_out <= '0;
      Rs1_addr_out <= '0;
      Rs2_addr_out <= '0;
      Rd_addr_out  <= '0;
      Imm_out      <= '0;
      ctrl_out     <= '0;
      if (!flush_IDEX && (bubble_cnt != c_CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + c_CNT_ONE;
      end
    end else if (en_IDEX) begin
      valid_out    <= valid_in;
      PC_out       <= PC_in;
      Rs1_data_out <= Rs1_data_in;
      Rs2_data_out <= Rs2_data_in;
      Rs1_addr_out <= Rs1_addr_in;
      Rs2_addr_out <= Rs2_addr_in;
      Rd_addr_out  <= Rd_addr_in;
      Imm_out      <= Imm_in;
      // An empty decode slot still loads its fields but carries no control.
      ctrl_out     <= valid_in ? ctrl_in : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_id_ex_reg.sv
// Self-checking bench for pipeline_id_ex_reg: expected snapshots are queued at drive
// time and compared after the capturing edge.
`default_nettype none

module tb_pipeline_id_ex_reg;

  localparam logic [19:0] c_LW  = 20'h0A000;
  localparam logic [19:0] c_ALU = 20'h08000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [19:0] ctrl;
    logic [15:0] cnt;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1, flush = 1'b0, valid_in = 1'b0;
  logic [31:0] pc_in = '0, r1d_in = '0, r2d_in = '0, imm_in = '0;
  logic [4:0]  r1a_in = '0, r2a_in = '0, rd_in = '0;
  logic        u1_in = 1'b0, u2_in = 1'b0;
  logic [19:0] ctrl_in = '0;

  logic        valid_out, stall;
  logic [31:0] pc_out, r1d_out, r2d_out, imm_out;
  logic [4:0]  r1a_out, r2a_out, rd_out;
  logic [19:0] ctrl_out;
  logic [15:0] cnt_out;

  // Second instance with a narrow counter so saturation is reachable quickly.
  logic        s_valid_in = 1'b0, s_u1 = 1'b0;
  logic [4:0]  s_r1a = '0, s_rd = '0;
  logic [19:0] s_ctrl = '0;
  logic        s_valid_out, s_stall;
  logic [31:0] s_pc_out, s_r1d_out, s_r2d_out, s_imm_out;
  logic [4:0]  s_r1a_out, s_r2a_out, s_rd_out;
  logic [19:0] s_ctrl_out;
  logic [3:0]  s_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_cnt  = 0;
  snap_t exp_q[$];
  logic [3:0] cnt_q[$];

  always #5 clk = ~clk;

  pipeline_id_ex_reg u_dut (
    .clk_IDEX(clk), .rst_IDEX(rst), .en_IDEX(en), .flush_IDEX(flush),
    .valid_in(valid_in), .PC_in(pc_in), .Rs1_data_in(r1d_in), .Rs2_data_in(r2d_in),
    .Rs1_addr_in(r1a_in), .Rs2_addr_in(r2a_in), .Rd_addr_in(rd_in),
    .Rs1_used_in(u1_in), .Rs2_used_in(u2_in), .Imm_in(imm_in), .ctrl_in(ctrl_in),
    .valid_out(valid_out), .PC_out(pc_out), .Rs1_data_out(r1d_out), .Rs2_data_out(r2d_out),
    .Rs1_addr_out(r1a_out), .Rs2_addr_out(r2a_out), .Rd_addr_out(rd_out),
    .Imm_out(imm_out), .ctrl_out(ctrl_out), .stall_out(stall), .bubble_cnt(cnt_out)
  );

  pipeline_id_ex_reg #(.XLEN(32), .CTRL_W(20), .CNT_W(4)) u_sat (
    .clk_IDEX(clk), .rst_IDEX(rst), .en_IDEX(1'b1), .flush_IDEX(1'b0),
    .valid_in(s_valid_in), .PC_in(32'h0), .Rs1_data_in(32'h0), .Rs2_data_in(32'h0),
    .Rs1_addr_in(s_r1a), .Rs2_addr_in(5'd0), .Rd_addr_in(s_rd),
    .Rs1_used_in(s_u1), .Rs2_used_in(1'b0), .Imm_in(32'h0), .ctrl_in(s_ctrl),
    .valid_out(s_valid_out), .PC_out(s_pc_out), .Rs1_data_out(s_r1d_out), .Rs2_data_out(s_r2d_out),
    .Rs1_addr_out(s_r1a_out), .Rs2_addr_out(s_r2a_out), .Rd_addr_out(s_rd_out),
    .Imm_out(s_imm_out), .ctrl_out(s_ctrl_out), .stall_out(s_stall), .bubble_cnt(s_cnt)
  );

  function automatic snap_t sample();
    snap_t s;
    s.valid = valid_out; s.pc = pc_out; s.r1d = r1d_out; s.r2d = r2d_out;
    s.r1a = r1a_out; s.r2a = r2a_out; s.rd = rd_out; s.imm = imm_out;
    s.ctrl = ctrl_out; s.cnt = cnt_out;
    return s;
  endfunction

  // Operand data is derived from the PC so each instruction carries distinct values.
  function automatic snap_t mk(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] rd,
                               input logic [31:0] imm, input logic [19:0] ctrl, input int cnt);
    snap_t s;
    s.valid = v; s.pc = pc; s.r1d = pc ^ 32'h1111_1111; s.r2d = pc ^ 32'h2222_2222;
    s.r1a = a1; s.r2a = a2; s.rd = rd; s.imm = imm; s.ctrl = ctrl; s.cnt = cnt[15:0];
    return s;
  endfunction

  function automatic snap_t bub(input int cnt);
    snap_t s = '0;
    s.cnt = cnt[15:0];
    return s;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [31:0] imm, input logic [19:0] ctrl);
    valid_in = v; pc_in = pc; r1d_in = pc ^ 32'h1111_1111; r2d_in = pc ^ 32'h2222_2222;
    r1a_in = a1; r2a_in = a2; rd_in = rd; u1_in = u1; u2_in = u2; imm_in = imm; ctrl_in = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t got;
    got = sample();
    n_checks++;
    if (got !== bub(0)) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", got, bub(0));
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b required 0", stall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_advance();
    snap_t got, e;
    @(negedge clk);
    drive(1'b1, 32'h0000_0010, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'hFFFF_FFFC, 20'h08003);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL advance_stall: got %b required 0", stall);
    end
    exp_q.push_back(mk(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFC, 20'h08003, exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL advance_capture: got %h required %h", got, e);
    end
    // An empty slot loads its fields but the control bundle is dropped.
    @(negedge clk);
    drive(1'b0, 32'h14, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'h1234, c_LW);
    exp_q.push_back(mk(1'b0, 32'h14, 5'd4, 5'd5, 5'd6, 32'h1234, 20'h0, exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL invalid_capture: got %h required %h", got, e);
    end
  endtask

  task automatic test_load_use();
    snap_t got, e;
    @(negedge clk);
    drive(1'b1, 32'h20, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, c_LW);
    exp_q.push_back(mk(1'b1, 32'h20, 5'd1, 5'd0, 5'd5, 32'h0, c_LW, exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL lu_load: got %h required %h", got, e);
    end
    @(negedge clk);
    drive(1'b1, 32'h24, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 32'h8, c_ALU);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall: got %b required 1", stall);
    end
    exp_cnt++;
    exp_q.push_back(bub(exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL lu_bubble: got %h required %h", got, e);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_stall_release: got %b required 0", stall);
    end
    exp_q.push_back(mk(1'b1, 32'h24, 5'd5, 5'd6, 5'd7, 32'h8, c_ALU, exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL lu_add_capture: got %h required %h", got, e);
    end
  endtask

  task automatic test_no_hazard();
    snap_t got, e;
    logic [19:0] ex_ctrl[3] = '{c_LW, c_LW, c_ALU};
    logic [4:0]  ex_rd[3]   = '{5'd0, 5'd5, 5'd5};
    logic [4:0]  d_a1[3]    = '{5'd0, 5'd9, 5'd5};
    logic [4:0]  d_a2[3]    = '{5'd0, 5'd5, 5'd3};
    logic        d_u2[3]    = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h40 + 32'(i * 8), 5'd2, 5'd3, ex_rd[i], 1'b1, 1'b1, 32'h0, ex_ctrl[i]);
      exp_q.push_back(mk(1'b1, 32'h40 + 32'(i * 8), 5'd2, 5'd3, ex_rd[i], 32'h0, ex_ctrl[i], exp_cnt));
      tick();
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL nohz_ex%0d: got %h required %h", i, got, e);
      end
      @(negedge clk);
      drive(1'b1, 32'h44 + 32'(i * 8), d_a1[i], d_a2[i], 5'd10, 1'b1, d_u2[i], 32'h5, c_ALU);
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL nohz_stall%0d: got %b required 0", i, stall);
      end
      exp_q.push_back(mk(1'b1, 32'h44 + 32'(i * 8), d_a1[i], d_a2[i], 5'd10, 32'h5, c_ALU, exp_cnt));
      tick();
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL nohz_dec%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_flush();
    snap_t got, e;
    @(negedge clk);
    drive(1'b1, 32'h80, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h0, c_LW);
    exp_q.push_back(mk(1'b1, 32'h80, 5'd1, 5'd2, 5'd5, 32'h0, c_LW, exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL flush_load: got %h required %h", got, e);
    end
    @(negedge clk);
    drive(1'b1, 32'h84, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, c_ALU);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_prehz: got %b required 1", stall);
    end
    en = 1'b0; flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b required 0", stall);
    end
    exp_q.push_back(bub(exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL flush_bubble: got %h required %h", got, e);
    end
    @(negedge clk);
    en = 1'b1; flush = 1'b0;
  endtask

  task automatic test_hold();
    snap_t got, e, held;
    held = mk(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 32'h0, c_LW, exp_cnt);
    @(negedge clk);
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h0, c_LW);
    exp_q.push_back(held);
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL hold_load: got %h required %h", got, e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0;
      drive(1'b1, 32'h200 + 32'(i * 4), 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 32'(i), c_ALU);
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL hold_stall%0d: got %b required 1", i, stall);
      end
      exp_q.push_back(held);
      tick();
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL hold_frozen%0d: got %h required %h", i, got, e);
      end
    end
    @(negedge clk);
    en = 1'b1;
    exp_cnt++;
    exp_q.push_back(bub(exp_cnt));
    tick();
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL hold_release_bubble: got %h required %h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    snap_t got, e;
    // lw x5; lw x6,(x5); add x7,x0,x6 -> two bubbles, one each.
    logic [31:0] pcs[5] = '{32'h300, 32'h304, 32'h304, 32'h308, 32'h308};
    logic [4:0]  a1s[5] = '{5'd1, 5'd5, 5'd5, 5'd0, 5'd0};
    logic [4:0]  a2s[5] = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd6};
    logic [4:0]  rds[5] = '{5'd5, 5'd6, 5'd6, 5'd7, 5'd7};
    logic        u2s[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [19:0] cts[5] = '{c_LW, c_LW, c_LW, c_ALU, c_ALU};
    logic        bbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, pcs[i], a1s[i], a2s[i], rds[i], 1'b1, u2s[i], 32'h0, cts[i]);
      if (bbl[i]) begin
        exp_cnt++;
        exp_q.push_back(bub(exp_cnt));
      end else begin
        exp_q.push_back(mk(1'b1, pcs[i], a1s[i], a2s[i], rds[i], 32'h0, cts[i], exp_cnt));
      end
      tick();
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL b2b_step%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t got;
    @(negedge clk);
    drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h0, c_LW);
    tick();
    @(negedge clk);
    drive(1'b1, 32'h404, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, c_ALU);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL arst_prestall: got %b required 1", stall);
    end
    #1;
    rst = 1'b1;
    #1;
    got = sample();
    exp_cnt = 0;
    n_checks++;
    if (got !== bub(0)) begin
      n_fail++; $display("FAIL arst_state: got %h required %h", got, bub(0));
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL arst_stall: got %b required 0", stall);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 20'h0);
  endtask

  task automatic test_saturation();
    logic [3:0] e;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_valid_in = 1'b1; s_ctrl = c_LW; s_rd = 5'd5; s_r1a = 5'd1; s_u1 = 1'b1;
      tick();
      @(negedge clk);
      s_ctrl = c_ALU; s_rd = 5'd9; s_r1a = 5'd5;
      cnt_q.push_back((i + 1 > 15) ? 4'hF : 4'(i + 1));
      tick();
      e = cnt_q.pop_front();
      n_checks++;
      if (s_cnt !== e) begin
        n_fail++; $display("FAIL sat_cnt%0d: got %h required %h", i, s_cnt, e);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    test_reset();
    test_advance();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
